// File: rtl/cmp_result_sender.sv
// Streams each new ALU/compare result word LSB-first as bytes into the UART TX FIFO.
// Define CMP_RESULT_SENDER_HOLD_BUF_EN to add a one-entry hold register for results arriving mid-frame.
module cmp_result_sender #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] res_data,
   input  logic                  res_valid,
   input  logic                  tx_ready,
   input  logic                  ovr_clr,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   output logic                  busy,
   output logic                  overrun
);

   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  res_valid_q, res_valid_d;
   logic                  overrun_q, overrun_d;

   logic new_res;
   logic hs;
   logic last_hs;
   logic accept;
   logic drop;
   logic pend_avail;

`ifdef CMP_RESULT_SENDER_HOLD_BUF_EN
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  hold_full_q, hold_full_d;
`endif

   // Handshake: a byte moves on every rising clk edge where tx_valid && tx_ready.
   // tx_valid/tx_data come straight from flops and stay put until that edge; tx_ready
   // only decides whether the transfer happens, never what is presented.
   always_comb begin
      res_valid_d = res_valid;
      new_res     = res_valid && !res_valid_q;
      hs          = (state_q == S_SEND) && tx_ready;
      last_hs     = hs && (idx_q == LAST_IDX);
      accept      = new_res && ((state_q == S_IDLE) || last_hs);
   end

`ifdef CMP_RESULT_SENDER_HOLD_BUF_EN
   assign pend_avail = hold_full_q;
`else
   assign pend_avail = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: a frame chains into the next one without an idle cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (new_res) begin
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (last_hs && !accept && !pend_avail) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: everything presented to the FIFO is a flop or a decode of the state flop
   always_comb begin
      tx_valid = (state_q == S_SEND);
      busy     = (state_q == S_SEND);
      tx_data  = shift_q[7:0];
      overrun  = overrun_q;
   end

   // Datapath next values
   always_comb begin
      shift_d   = shift_q;
      idx_d     = idx_q;
      overrun_d = overrun_q;
      drop      = 1'b0;
`ifdef CMP_RESULT_SENDER_HOLD_BUF_EN
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
`endif

      if (hs) begin
         shift_d = shift_q >> 8;
         idx_d   = last_hs ? '0 : idx_q + IDX_W'(1);
      end

`ifdef CMP_RESULT_SENDER_HOLD_BUF_EN
      // The held word is older than anything arriving now, so it goes out first
      if (last_hs && hold_full_q) begin
         shift_d     = hold_q;
         idx_d       = '0;
         hold_full_d = 1'b0;
      end
      if (new_res) begin
         if (accept && !(last_hs && hold_full_q)) begin
            shift_d = res_data;
            idx_d   = '0;
         end else if (accept || !hold_full_q) begin
            hold_d      = res_data;
            hold_full_d = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end
`else
      if (new_res) begin
         if (accept) begin
            shift_d = res_data;
            idx_d   = '0;
         end else begin
            drop = 1'b1;
         end
      end
`endif

      // A drop in the same cycle as a clear keeps the flag set
      if (drop) begin
         overrun_d = 1'b1;
      end else if (ovr_clr) begin
         overrun_d = 1'b0;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q     <= '0;
         idx_q       <= '0;
         res_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef CMP_RESULT_SENDER_HOLD_BUF_EN
         hold_q      <= '0;
         hold_full_q <= 1'b0;
`endif
      end else begin
         shift_q     <= shift_d;
         idx_q       <= idx_d;
         res_valid_q <= res_valid_d;
         overrun_q   <= overrun_d;
`ifdef CMP_RESULT_SENDER_HOLD_BUF_EN
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
`endif
      end
   end

endmodule
